// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage pipelined IEEE-754 style floating-point adder/subtractor.
//   S1: unpack, classify, order operands by magnitude, align smaller significand (guard/round/sticky)
//   S2: significand add/subtract, leading-zero normalise
//   S3: round, exponent adjust, pack, flags (registered straight onto the outputs)
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   valid_i / ready_o      operation handshake (ready_o is the combinational pipeline enable)
//   addsub_i               0 = A+B, 1 = A-B
//   rnd_mode_i             00 RNE, 01 RTZ, 10 RDN, 11 RUP
//   data_a_i, data_b_i     operands {sign, exponent, fraction}
//   valid_o / ready_i      result handshake
//   result_o, flags_o      rounded result, {invalid, overflow, underflow, inexact}
// Configuration macro FP_ADDSUB_SUBNORM_EN: gradual subnormal support when defined,
// otherwise subnormal inputs read as signed zero and tiny results flush to signed zero.
module fp_addsub_pipe #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 24
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     valid_i,
    output logic                                     ready_o,
    input  logic                                     addsub_i,
    input  logic [1:0]                               rnd_mode_i,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] data_a_i,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] data_b_i,
    output logic                                     valid_o,
    input  logic                                     ready_i,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] result_o,
    output logic [3:0]                               flags_o
);
    localparam int E  = EXPONENT_WIDTH;
    localparam int M  = MANTISSA_WIDTH;
    localparam int F  = M - 1;
    localparam int W  = E + M;
    localparam int SW = M + 3;   // significand plus guard, round, sticky
    localparam int XW = 16;      // working exponent width, ample for all legal parameters

    localparam logic [XW-1:0] EMAX = XW'((1 << E) - 1);
    localparam logic [W-1:0]  QNAN = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rnd_e;

    logic en;

    // ---------------- stage registers ----------------
    logic           s1_valid_q, s1_valid_d;
    logic           s1_sign_q, s1_sign_d;
    logic           s1_zsign_q, s1_zsign_d;
    logic           s1_eff_sub_q, s1_eff_sub_d;
    logic [E-1:0]   s1_exp_q, s1_exp_d;
    logic [SW-1:0]  s1_sig_x_q, s1_sig_x_d;
    logic [SW-1:0]  s1_sig_y_q, s1_sig_y_d;
    logic           s1_special_q, s1_special_d;
    logic [W-1:0]   s1_sp_res_q, s1_sp_res_d;
    logic [3:0]     s1_sp_flags_q, s1_sp_flags_d;
    rnd_e           s1_rnd_q, s1_rnd_d;

    logic           s2_valid_q, s2_valid_d;
    logic           s2_sign_q, s2_sign_d;
    logic           s2_zsign_q, s2_zsign_d;
    logic           s2_zero_q, s2_zero_d;
    logic           s2_tiny_q, s2_tiny_d;
    logic [XW-1:0]  s2_exp_q, s2_exp_d;
    logic [SW-1:0]  s2_sig_q, s2_sig_d;
    logic           s2_special_q, s2_special_d;
    logic [W-1:0]   s2_sp_res_q, s2_sp_res_d;
    logic [3:0]     s2_sp_flags_q, s2_sp_flags_d;
    rnd_e           s2_rnd_q, s2_rnd_d;

    logic           valid_q, valid_d;
    logic [W-1:0]   result_q, result_d;
    logic [3:0]     flags_q, flags_d;

    assign en       = ready_i | ~valid_q;
    assign ready_o  = en;
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign flags_o  = flags_q;

    // ---------------- S1: unpack / classify / swap / align ----------------
    logic              sa, sb, sb_raw, sx;
    logic [E-1:0]      ea, eb, xa, xb, ex, ey;
    logic [F-1:0]      fa, fb;
    logic [M-1:0]      ma, mb, mx, my;
    logic              a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_sub, b_sub;
    logic              swap, inf_inv, any_nan;
    logic [XW-1:0]     dexp, shamt;
    logic [M+SW-1:0]   wide;

    always_comb begin
        {sa, ea, fa}   = data_a_i;
        {sb_raw, eb, fb} = data_b_i;
        sb     = sb_raw ^ addsub_i;
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_snan = a_nan & ~fa[F-1];
        b_snan = b_nan & ~fb[F-1];
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);
        a_sub  = (ea == '0);
        b_sub  = (eb == '0);
`ifdef FP_ADDSUB_SUBNORM_EN
        ma = {~a_sub, fa};
        mb = {~b_sub, fb};
        xa = a_sub ? {{(E-1){1'b0}}, 1'b1} : ea;
        xb = b_sub ? {{(E-1){1'b0}}, 1'b1} : eb;
`else
        ma = a_sub ? '0 : {1'b1, fa};
        mb = b_sub ? '0 : {1'b1, fb};
        xa = ea;
        xb = eb;
`endif
        swap = {xb, mb} > {xa, ma};
        ex   = swap ? xb : xa;
        ey   = swap ? xa : xb;
        mx   = swap ? mb : ma;
        my   = swap ? ma : mb;
        sx   = swap ? sb : sa;

        // Shifts past SW leave only sticky information, so the shift is capped there.
        dexp  = XW'(ex) - XW'(ey);
        shamt = (dexp > XW'(SW)) ? XW'(SW) : dexp;
        wide  = {my, {SW{1'b0}}} >> shamt;

        any_nan = a_nan | b_nan;
        inf_inv = a_inf & b_inf & (sa ^ sb);

        s1_valid_d    = valid_i;
        s1_sign_d     = sx;
        s1_eff_sub_d  = sa ^ sb;
        // An exact zero from opposite signs is +0 except under RDN; same signs keep the sign.
        s1_zsign_d    = (sa ^ sb) ? (rnd_mode_i == RM_RDN) : sx;
        s1_exp_d      = ex;
        s1_sig_x_d    = {mx, 3'b000};
        s1_sig_y_d    = {wide[M+SW-1 -: SW-1], |wide[M:0]};
        s1_special_d  = any_nan | a_inf | b_inf;
        s1_sp_flags_d = {a_snan | b_snan | inf_inv, 3'b000};
        if (any_nan || inf_inv) begin
            s1_sp_res_d = QNAN;
        end else if (a_inf) begin
            s1_sp_res_d = {sa, {E{1'b1}}, {F{1'b0}}};
        end else begin
            s1_sp_res_d = {sb, {E{1'b1}}, {F{1'b0}}};
        end
        s1_rnd_d      = rnd_e'(rnd_mode_i);
    end

    // ---------------- S2: add/subtract and normalise ----------------
    logic [SW:0]    sum;
    logic [XW-1:0]  exp0, lz, sh;
    logic           found;

    always_comb begin
        sum   = s1_eff_sub_q ? ({1'b0, s1_sig_x_q} - {1'b0, s1_sig_y_q})
                             : ({1'b0, s1_sig_x_q} + {1'b0, s1_sig_y_q});
        exp0  = XW'(s1_exp_q);
        lz    = XW'(SW);
        found = 1'b0;
        for (int unsigned i = 0; i < SW; i++) begin
            if (!found && sum[SW-1-i]) begin
                lz    = XW'(i);
                found = 1'b1;
            end
        end
        sh        = '0;
        s2_tiny_d = 1'b0;
        if (sum[SW]) begin
            // Carry out: shift right once, folding the dropped bit into sticky.
            s2_sig_d = {sum[SW:2], sum[1] | sum[0]};
            s2_exp_d = exp0 + XW'(1);
        end else begin
`ifdef FP_ADDSUB_SUBNORM_EN
            // Stop normalising at the minimum exponent so the result denormalises gradually.
            sh = (lz > exp0 - XW'(1)) ? exp0 - XW'(1) : lz;
`else
            sh        = lz;
            s2_tiny_d = (lz >= exp0);
`endif
            s2_sig_d = sum[SW-1:0] << sh;
            s2_exp_d = exp0 - sh;
        end
        s2_valid_d    = s1_valid_q;
        s2_sign_d     = s1_sign_q;
        s2_zsign_d    = s1_zsign_q;
        s2_zero_d     = (sum == '0);
        s2_special_d  = s1_special_q;
        s2_sp_res_d   = s1_sp_res_q;
        s2_sp_flags_d = s1_sp_flags_q;
        s2_rnd_d      = s1_rnd_q;
    end

    // ---------------- S3: round / pack / flags ----------------
    logic [M-1:0]   sig_m, sig_r;
    logic [M:0]     rounded;
    logic [XW-1:0]  exp_r;
    logic           g, rs, inexact, up, ovf, to_inf;

    always_comb begin
        sig_m   = s2_sig_q[SW-1:3];
        g       = s2_sig_q[2];
        rs      = |s2_sig_q[1:0];
        inexact = g | rs;
        case (s2_rnd_q)
            RM_RNE:  up = g & (rs | sig_m[0]);
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = inexact & s2_sign_q;
            default: up = inexact & ~s2_sign_q;
        endcase
        rounded = {1'b0, sig_m} + {{M{1'b0}}, up};
        if (rounded[M]) begin
            sig_r = rounded[M:1];
            exp_r = s2_exp_q + XW'(1);
        end else begin
            sig_r = rounded[M-1:0];
            exp_r = s2_exp_q;
        end
        ovf    = sig_r[M-1] && (exp_r >= EMAX);
        to_inf = (s2_rnd_q == RM_RNE) || ((s2_rnd_q == RM_RUP) && !s2_sign_q) ||
                 ((s2_rnd_q == RM_RDN) && s2_sign_q);

        // A cleared hidden bit means a subnormal encoding with a zero exponent field.
        result_d = {s2_sign_q, (sig_r[M-1] ? exp_r[E-1:0] : {E{1'b0}}), sig_r[F-1:0]};
        flags_d  = {2'b00, ~sig_r[M-1] & inexact, inexact};
        if (s2_special_q) begin
            result_d = s2_sp_res_q;
            flags_d  = s2_sp_flags_q;
        end else if (s2_zero_q) begin
            result_d = {s2_zsign_q, {(W-1){1'b0}}};
            flags_d  = 4'b0000;
        end else if (s2_tiny_q) begin
            result_d = {s2_sign_q, {(W-1){1'b0}}};
            flags_d  = 4'b0011;
        end else if (ovf) begin
            result_d = to_inf ? {s2_sign_q, {E{1'b1}}, {F{1'b0}}}
                              : {s2_sign_q, {(E-1){1'b1}}, 1'b0, {F{1'b1}}};
            flags_d  = 4'b0101;
        end
        valid_d = s2_valid_q;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else if (en) begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en) begin
            s1_sign_q     <= s1_sign_d;
            s1_zsign_q    <= s1_zsign_d;
            s1_eff_sub_q  <= s1_eff_sub_d;
            s1_exp_q      <= s1_exp_d;
            s1_sig_x_q    <= s1_sig_x_d;
            s1_sig_y_q    <= s1_sig_y_d;
            s1_special_q  <= s1_special_d;
            s1_sp_res_q   <= s1_sp_res_d;
            s1_sp_flags_q <= s1_sp_flags_d;
            s1_rnd_q      <= s1_rnd_d;
            s2_sign_q     <= s2_sign_d;
            s2_zsign_q    <= s2_zsign_d;
            s2_zero_q     <= s2_zero_d;
            s2_tiny_q     <= s2_tiny_d;
            s2_exp_q      <= s2_exp_d;
            s2_sig_q      <= s2_sig_d;
            s2_special_q  <= s2_special_d;
            s2_sp_res_q   <= s2_sp_res_d;
            s2_sp_flags_q <= s2_sp_flags_d;
            s2_rnd_q      <= s2_rnd_d;
        end
    end

endmodule
